// File: rtl/alu_stim_driver.sv
// alu_stim_driver
// Automatic operator for the switch/button/LED ALU test harness. Accepts one
// test vector over a valid/ready handshake, walks the harness through its
// five steps (A, B, opcode, result display, flag display) by driving SW and
// pulsing the active-low NXT button. It checks the LED bus at the result and
// flag steps and reports pass/fail with saturating counters.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   vec_valid/vec_ready   vector handshake, accepted when both are high at CLK
//   vec_a/b/op/res/flags  operands, opcode, expected result, expected {c,v,n,z}
//   SW, NXT               switch bus and step button (idle high) to harness
//   L                     LED bus from harness
//   done/pass/fail        one-cycle end-of-vector report
//   pass_cnt/fail_cnt     saturating vector counters
//   last_res              L sampled at the result check
//
// Parameters SETUP_CYC, PULSE_CYC, SETTLE_CYC: legal range 1..255.
//
// state   | meaning
// IDLE    | waiting for a vector, vec_ready high, SW=0
// SETUP   | SW holds the phase value, NXT high; checks sampled on last cycle
// PRESS   | NXT low
// RELEASE | NXT high, harness settles; advance phase or finish
// DONE    | one-cycle report, counters update
module alu_stim_driver #(
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        vec_valid,
  output logic        vec_ready,
  input  logic [15:0] vec_a,
  input  logic [15:0] vec_b,
  input  logic [3:0]  vec_op,
  input  logic [15:0] vec_res,
  input  logic [3:0]  vec_flags,
  output logic [15:0] SW,
  output logic        NXT,
  input  logic [15:0] L,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  pass_cnt,
  output logic [7:0]  fail_cnt,
  output logic [15:0] last_res
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRESS,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [2:0]  r_p;
  logic [7:0]  r_cnt;
  logic [7:0]  w_reload;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_op;
  logic [15:0] r_res;
  logic [3:0]  r_flags;
  logic        r_res_ok;
  logic        r_flg_ok;
  logic        w_accept;
  logic        w_cnt_zero;
  logic        w_all_ok;
  logic [15:0] w_sw_phase;

  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_accept   = vec_valid & vec_ready;
  assign w_all_ok   = r_res_ok & r_flg_ok;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept)   w_state_nx = ST_SETUP;
      ST_SETUP:   if (w_cnt_zero) w_state_nx = ST_PRESS;
      ST_PRESS:   if (w_cnt_zero) w_state_nx = ST_RELEASE;
      ST_RELEASE: if (w_cnt_zero) w_state_nx = (r_p == 3'd4) ? ST_DONE : ST_SETUP;
      ST_DONE:    w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  // Every timed state is entered from a different state, so a state change
  // is exactly the reload condition.
  always_comb begin
    w_reload = 8'd0;
    case (w_state_nx)
      ST_SETUP:   w_reload = 8'(SETUP_CYC - 1);
      ST_PRESS:   w_reload = 8'(PULSE_CYC - 1);
      ST_RELEASE: w_reload = 8'(SETTLE_CYC - 1);
      default:    w_reload = 8'd0;
    endcase
  end

  always_comb begin
    w_sw_phase = 16'h0000;
    case (r_p)
      3'd0:    w_sw_phase = r_a;
      3'd1:    w_sw_phase = r_b;
      3'd2:    w_sw_phase = {12'b0, r_op};
      default: w_sw_phase = 16'h0000;
    endcase
  end

  // Outputs decode the registered state, so reset forces SW=0 / NXT=1 at once.
  assign vec_ready = (r_state == ST_IDLE) & ~RST;
  assign NXT       = (r_state != ST_PRESS);
  assign SW        = (r_state == ST_IDLE || r_state == ST_DONE) ? 16'h0000 : w_sw_phase;
  assign done      = (r_state == ST_DONE);
  assign pass      = done & w_all_ok;
  assign fail      = done & ~w_all_ok;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_p      <= 3'd0;
      r_cnt    <= 8'd0;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_op     <= 4'h0;
      r_res    <= 16'h0000;
      r_flags  <= 4'h0;
      r_res_ok <= 1'b0;
      r_flg_ok <= 1'b0;
      pass_cnt <= 8'd0;
      fail_cnt <= 8'd0;
      last_res <= 16'h0000;
    end else begin
      r_state <= w_state_nx;

      if (w_state_nx != r_state)
        r_cnt <= w_reload;
      else if (!w_cnt_zero)
        r_cnt <= r_cnt - 8'd1;

      if (w_accept) begin
        r_a     <= vec_a;
        r_b     <= vec_b;
        r_op    <= vec_op;
        r_res   <= vec_res;
        r_flags <= vec_flags;
        r_p     <= 3'd0;
      end

      if (r_state == ST_SETUP && w_cnt_zero) begin
        if (r_p == 3'd3) begin
          r_res_ok <= (L == r_res);
          last_res <= L;
        end
        if (r_p == 3'd4)
          r_flg_ok <= (L == {12'b0, r_flags});
      end

      if (r_state == ST_RELEASE && w_cnt_zero && r_p != 3'd4)
        r_p <= r_p + 3'd1;

      if (r_state == ST_DONE) begin
        if (w_all_ok) begin
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
        end else begin
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
        end
      end
    end
  end

endmodule
